if_id_buffer: RTL and testbench

Fetch-to-decode decoupling stage placed directly downstream of the fetch stage. It captures each fetched instruction, its PC+2 and its fetch error flag into a small in-order queue, and presents the oldest entry to decode. It throttles fetch by asserting stall_pc when the queue is full or a HALT is pending. It squashes everything on a branch flush. Empty slots present a NOP to decode so that decode never sees garbage.

---
 rtl/ifid_pkg.sv | 17 +
 rtl/ifid_queue_mem.sv | 25 ++
 rtl/if_id_buffer.sv | 96 +++++++++
 tb/tb_if_id_buffer.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/ifid_pkg.sv
// Shared constants and entry layout for the fetch-to-decode buffer.
package ifid_pkg;

  localparam int IW   = 16;
  localparam int AW   = 16;
  localparam int SQ_W = 16;

  localparam logic [IW-1:0] NOP_INST  = 16'h0800;
  localparam logic [IW-1:0] HALT_INST = 16'h0000;

  typedef struct packed {
    logic [IW-1:0] inst;
    logic [AW-1:0] pcplus2;
    logic          err;
  } entry_t;

endpackage

// File: rtl/ifid_queue_mem.sv
// DEPTH-entry register file: one synchronous write port, one combinational read port.
module ifid_queue_mem
  import ifid_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  entry_t                   wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output entry_t                   rdata_o
);

  entry_t mem_q [DEPTH];

  // NOTE: storage is deliberately not reset; the parent's count decides which slots are live,
  // so stale contents are never presented.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/if_id_buffer.sv
// In-order fetch-to-decode queue with fetch throttling, HALT blocking and flush squash counting.
module if_id_buffer
  import ifid_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [IW-1:0]   inst_in,
  input  logic [AW-1:0]   pcplus2_in,
  input  logic            err_in,
  input  logic            if_valid,
  input  logic            flush,
  input  logic            id_stall,
  output logic [IW-1:0]   inst_out,
  output logic [AW-1:0]   pcplus2_out,
  output logic            err_out,
  output logic            id_valid,
  output logic            stall_pc,
  output logic [SQ_W-1:0] squash_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [PW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            halt_pend_q, halt_pend_d;
  logic [SQ_W-1:0] squash_q, squash_d;
  logic            full, accept, pop;
  entry_t          wr_entry, head;

  assign full   = (count_q == CW'(DEPTH));
  assign accept = if_valid & ~full & ~halt_pend_q & ~flush;
  assign pop    = (count_q != '0) & ~id_stall & ~flush;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    halt_pend_d = halt_pend_q;
    squash_d    = squash_q;
    if (flush) begin
      rd_ptr_d    = '0;
      wr_ptr_d    = '0;
      count_d     = '0;
      halt_pend_d = 1'b0;
      // The fetch slot offered alongside the flush is squashed too.
      squash_d    = squash_q + SQ_W'(count_q) + SQ_W'(if_valid);
    end else begin
      if (accept) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
        if (inst_in == HALT_INST) halt_pend_d = 1'b1;
      end
      if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + CW'(accept) - CW'(pop);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      halt_pend_q <= 1'b0;
      squash_q    <= '0;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      halt_pend_q <= halt_pend_d;
      squash_q    <= squash_d;
    end
  end

  assign wr_entry = '{inst: inst_in, pcplus2: pcplus2_in, err: err_in};

  ifid_queue_mem #(.DEPTH(DEPTH)) u_mem (
    .clk     (clk),
    .we_i    (accept),
    .waddr_i (wr_ptr_q),
    .wdata_i (wr_entry),
    .raddr_i (rd_ptr_q),
    .rdata_o (head)
  );

  assign id_valid    = (count_q != '0);
  assign inst_out    = id_valid ? head.inst    : NOP_INST;
  assign pcplus2_out = id_valid ? head.pcplus2 : '0;
  assign err_out     = id_valid & head.err;
  assign stall_pc    = full | halt_pend_q;
  assign squash_cnt  = squash_q;

endmodule

// File: tb/tb_if_id_buffer.sv
// Scoreboard bench for if_id_buffer: directed stimulus pushes expected entries, a monitor checks pops.
`timescale 1ns/1ps
module tb_if_id_buffer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] inst_in = '0;
  logic [15:0] pcplus2_in = '0;
  logic        err_in = 1'b0;
  logic        if_valid = 1'b0;
  logic        flush = 1'b0;
  logic        id_stall = 1'b0;
  logic [15:0] inst_out;
  logic [15:0] pcplus2_out;
  logic        err_out;
  logic        id_valid;
  logic        stall_pc;
  logic [15:0] squash_cnt;

  typedef struct {
    logic [15:0] inst;
    logic [15:0] pc;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  if_id_buffer #(.DEPTH(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .inst_in     (inst_in),
    .pcplus2_in  (pcplus2_in),
    .err_in      (err_in),
    .if_valid    (if_valid),
    .flush       (flush),
    .id_stall    (id_stall),
    .inst_out    (inst_out),
    .pcplus2_out (pcplus2_out),
    .err_out     (err_out),
    .id_valid    (id_valid),
    .stall_pc    (stall_pc),
    .squash_cnt  (squash_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] i, input logic [15:0] p,
                       input logic e, input logic st, input logic fl);
    if_valid   = v;
    inst_in    = i;
    pcplus2_in = p;
    err_in     = e;
    id_stall   = st;
    flush      = fl;
  endtask

  task automatic expect_entry(input logic [15:0] i, input logic [15:0] p, input logic e);
    exp_t x;
    x.inst = i;
    x.pc   = p;
    x.err  = e;
    exp_q.push_back(x);
  endtask

  // Monitor: a pop happens at the next rising edge whenever these conditions hold at the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (rst && id_valid && !id_stall && !flush) begin
        if (exp_q.size() == 0) begin
          check("pop_unexpected_inst", 32'(inst_out), 32'hFFFF_FFFF);
        end else begin
          exp_t x;
          x = exp_q.pop_front();
          check("pop_inst", 32'(inst_out), 32'(x.inst));
          check("pop_pc", 32'(pcplus2_out), 32'(x.pc));
          check("pop_err", 32'(err_out), 32'(x.err));
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset and empty
    drive(0, 16'h0, 16'h0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    tick();
    check("rst_valid", 32'(id_valid), 0);
    check("rst_inst", 32'(inst_out), 32'h0800);
    check("rst_pc", 32'(pcplus2_out), 0);
    check("rst_err", 32'(err_out), 0);
    check("rst_stall", 32'(stall_pc), 0);
    check("rst_squash", 32'(squash_cnt), 0);

    // Streaming
    drive(1, 16'h4001, 16'd2, 0, 0, 0); expect_entry(16'h4001, 16'd2, 0); tick();
    check("stream_lat_valid", 32'(id_valid), 1);
    check("stream_lat_inst", 32'(inst_out), 32'h4001);
    check("stream_stall1", 32'(stall_pc), 0);
    drive(1, 16'h4002, 16'd4, 0, 0, 0); expect_entry(16'h4002, 16'd4, 0); tick();
    check("stream_inst2", 32'(inst_out), 32'h4002);
    check("stream_stall2", 32'(stall_pc), 0);
    drive(1, 16'h4003, 16'd6, 0, 0, 0); expect_entry(16'h4003, 16'd6, 0); tick();
    check("stream_inst3", 32'(inst_out), 32'h4003);
    check("stream_stall3", 32'(stall_pc), 0);
    drive(0, 16'h0, 16'h0, 0, 0, 0); tick();
    check("stream_drained", 32'(id_valid), 0);

    // Backpressure
    drive(1, 16'hA0A0, 16'd10, 0, 1, 0); expect_entry(16'hA0A0, 16'd10, 0); tick();
    check("bp_stall_one", 32'(stall_pc), 0);
    drive(1, 16'hB0B0, 16'd12, 0, 1, 0); expect_entry(16'hB0B0, 16'd12, 0); tick();
    check("bp_stall_full", 32'(stall_pc), 1);
    drive(1, 16'hC0C0, 16'd14, 0, 1, 0); tick();
    check("bp_head_held", 32'(inst_out), 32'hA0A0);
    check("bp_stall_held", 32'(stall_pc), 1);
    drive(0, 16'h0, 16'h0, 0, 0, 0); tick();
    check("bp_stall_drop", 32'(stall_pc), 0);
    check("bp_head_b", 32'(inst_out), 32'hB0B0);
    tick();
    check("bp_empty", 32'(id_valid), 0);

    // Flush with two queued entries plus an offered fetch
    drive(1, 16'hD001, 16'd30, 0, 1, 0); tick();
    drive(1, 16'hD002, 16'd32, 0, 1, 0); tick();
    check("fl_full", 32'(stall_pc), 1);
    drive(1, 16'hE001, 16'd34, 0, 1, 1); tick();
    drive(0, 16'h0, 16'h0, 0, 0, 0);
    check("fl_valid", 32'(id_valid), 0);
    check("fl_inst", 32'(inst_out), 32'h0800);
    check("fl_pc", 32'(pcplus2_out), 0);
    check("fl_stall", 32'(stall_pc), 0);
    check("fl_squash", 32'(squash_cnt), 3);

    // HALT blocks fetch until a flush
    drive(1, 16'h4001, 16'd20, 0, 0, 0); expect_entry(16'h4001, 16'd20, 0); tick();
    check("halt_pre_stall", 32'(stall_pc), 0);
    drive(1, 16'h0000, 16'd22, 0, 0, 0); expect_entry(16'h0000, 16'd22, 0); tick();
    check("halt_stall", 32'(stall_pc), 1);
    check("halt_head", 32'(inst_out), 32'h0000);
    drive(1, 16'h4005, 16'd24, 0, 0, 0); tick();
    check("halt_blocked_valid", 32'(id_valid), 0);
    check("halt_blocked_stall", 32'(stall_pc), 1);
    tick();
    check("halt_still_empty", 32'(id_valid), 0);
    drive(0, 16'h0, 16'h0, 0, 0, 1); tick();
    drive(0, 16'h0, 16'h0, 0, 0, 0);
    check("halt_flush_stall", 32'(stall_pc), 0);
    check("halt_flush_squash", 32'(squash_cnt), 3);

    // Error tagging across several pointer wraps
    for (int k = 1; k <= 6; k++) begin
      drive(1, 16'h5000 + 16'(k), 16'(40 + 2 * k), (k == 2), 0, 0);
      expect_entry(16'h5000 + 16'(k), 16'(40 + 2 * k), (k == 2));
      tick();
      check("err_inst", 32'(inst_out), 32'h5000 + 32'(k));
      check("err_flag", 32'(err_out), 32'(k == 2));
    end
    drive(0, 16'h0, 16'h0, 0, 0, 0); tick();
    check("err_empty_valid", 32'(id_valid), 0);
    check("err_empty_flag", 32'(err_out), 0);

    // Squash counter wrap: each flush with an offered fetch on an empty queue adds one
    drive(1, 16'hF000, 16'h0, 0, 0, 1);
    repeat (65535 - 3) tick();
    check("sq_preload", 32'(squash_cnt), 32'hFFFF);
    drive(1, 16'hF001, 16'd50, 0, 1, 0); tick();
    drive(0, 16'h0, 16'h0, 0, 1, 1); tick();
    drive(0, 16'h0, 16'h0, 0, 0, 0);
    check("sq_wrap", 32'(squash_cnt), 0);
    check("sq_wrap_valid", 32'(id_valid), 0);

    tick();
    check("sb_drained", 32'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
